dff_mux_tester: RTL
===================

// Module: dff_mux_tester
// PURPOSE
//  Synthesizable self-checking driver for the mux-select D flip-flop block (inputs d/rst/sel, output q).
//  Drives rst/sel/d into the flop, reads q back and checks it against the expected value.
//  Runs a fixed sequence: synchronous-reset check, then a load-D0 sweep, then a load-D1 sweep.
//  Reports the run status as pass/fail, an error count and the phase of the first failure.
//  Sits beside the flop instance; used for on-chip/FPGA self-test and as a bench building block.
// PARAMETERS
//  SETTLE    2      clocks per vector, from driving the outputs to sampling dut_q (legal: >=2)
//  NUM_VEC   8      vectors in each load phase (legal: 1..255)
//  LFSR_SEED 8'hA5  data LFSR seed (must be nonzero)
//  ERR_W     8      width of err_cnt (saturating counter)
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      asynchronous reset, active-high
//  start      in   1      begin a run; sampled only in IDLE or DONE
//  dut_rst    out  1      drives the flop's synchronous reset
//  dut_sel    out  1      drives the flop's select: 0=load d, 1=load ~d
//  dut_d      out  1      drives the flop's data input
//  dut_q      in   1      q read back from the flop
//  busy       out  1      high while a run is in progress
//  done       out  1      high in DONE; held until the next start
//  pass       out  1      done && err_cnt==0
//  err_cnt    out  ERR_W  count of mismatches; saturates at all-ones
//  vec_cnt    out  8      count of vectors checked in the current run
//  fail_phase out  2      phase of the first mismatch: 0=none, 1=RESET, 2=LOAD_D0, 3=LOAD_D1
// BEHAVIOUR
//  Reset (async, asserted):
//   - dut_rst=1; dut_sel=0; dut_d=0.
//   - busy=0; done=0; pass=0; err_cnt=0; vec_cnt=0; fail_phase=0.
//   - LFSR loaded with LFSR_SEED; FSM goes to IDLE. Takes effect immediately, including mid-run.
//  FSM states: IDLE -> RESET_CHK -> LOAD_D0 -> LOAD_D1 -> DONE.
//   - DONE returns to RESET_CHK on start.
//  On a start edge accepted in IDLE or DONE:
//   - clear err_cnt, vec_cnt, fail_phase and done.
//   - reload the LFSR with LFSR_SEED; set busy=1.
//  start while busy: ignored, with no effect on the current run.
//  Vector timing:
//   - Outputs are registered and applied after edge N.
//   - dut_q is compared at edge N+SETTLE; the next vector is applied at that same edge.
//   - Every vector takes exactly SETTLE clocks.
//  Data source and expected values:
//   - b = LFSR[0]. LFSR is Fibonacci x^8+x^6+x^5+x^4+1, advancing once per vector.
//   - RESET_CHK: 1 vector; dut_rst=1, dut_sel=LFSR[1], dut_d=b; expect q=0.
//   - LOAD_D0: NUM_VEC vectors; dut_rst=0, dut_sel=0, dut_d=b; expect q=b.
//   - LOAD_D1: NUM_VEC vectors; dut_rst=0, dut_sel=1, dut_d=~b; expect q=b.
//  On each compare:
//   - vec_cnt increments.
//   - On mismatch (dut_q!==expected, X counts as a mismatch): err_cnt increments unless already all-ones.
//   - fail_phase is set only if it is currently 0.
//  Run does not stop on error; it always completes every phase.
//  After the final compare:
//   - state=DONE, busy=0, done=1.
//   - dut_rst returns to 1 to park the flop in reset.
//  Total run length: SETTLE*(1+2*NUM_VEC) clocks from start acceptance to done.
// TESTING
//  1 Assert rst for 3 clk -> dut_rst=1, busy=0, done=0, err_cnt=0, fail_phase=0.
//  2 Correct flop, defaults, pulse start -> busy for 34 clk, then done=1, pass=1, err_cnt=0, vec_cnt=17.
//  3 Flop ignores sel (always loads d) -> done, pass=0, err_cnt=8, fail_phase=3.
//  4 Flop q stuck-at-1 -> fail_phase=1; err_cnt = 1 + count of b==0 vectors in the load phases (from LFSR model).
//  5 rst asserted mid LOAD_D0, then released; start again -> immediate reset values; second run pass=1.
//  6 start pulsed while busy -> run unchanged; with ERR_W=2 and a stuck-at-0 flop, err_cnt saturates at 3.

Source files
------------

// File: rtl/dff_mux_tester_if.sv
// Bundle between the mux-select flop self-test driver, the flop under test and the run controller.
// The master side is the tester; the slave side is whoever starts runs and models or hosts the flop.
interface dff_mux_tester_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic             dut_rst;
   logic             dut_sel;
   logic             dut_d;
   logic             dut_q;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [7:0]       vec_cnt;
   logic [1:0]       fail_phase;

   modport master (
      input  start, dut_q,
      output dut_rst, dut_sel, dut_d, busy, done, pass, err_cnt, vec_cnt, fail_phase
   );

   modport slave (
      output start, dut_q,
      input  dut_rst, dut_sel, dut_d, busy, done, pass, err_cnt, vec_cnt, fail_phase
   );
endinterface

// File: rtl/dff_mux_tester.sv
// Self-checking driver for the mux-select D flop: synchronous-reset check, then load-D0 and
// load-D1 sweeps fed from an LFSR, with saturating error count and first-failure phase.
module dff_mux_tester #(
   parameter int         SETTLE    = 2,
   parameter int         NUM_VEC   = 8,
   parameter logic [7:0] LFSR_SEED = 8'hA5,
   parameter int         ERR_W     = 8
) (
   input logic               clk,
   input logic               rst,
   dff_mux_tester_if.master  bus
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RESET_CHK = 3'd1;
   localparam logic [2:0] ST_LOAD_D0   = 3'd2;
   localparam logic [2:0] ST_LOAD_D1   = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   localparam int              TMR_W    = $clog2(SETTLE);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE - 1);
   localparam logic [7:0]       PH_LAST  = 8'(NUM_VEC - 1);

   // Fibonacci x^8+x^6+x^5+x^4+1, new bit enters at bit 0
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   logic [2:0]       state_r;
   logic [7:0]       lfsr_r;
   logic [TMR_W-1:0] tmr_r;
   logic [7:0]       ph_cnt_r;
   logic             exp_r;
   logic             dut_rst_r;
   logic             dut_sel_r;
   logic             dut_d_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [ERR_W-1:0] err_cnt_r;
   logic [7:0]       vec_cnt_r;
   logic [1:0]       fail_phase_r;

   logic             start_ok_s;
   logic             cmp_s;
   logic             mism_s;
   logic [7:0]       lfsr_n_s;
   logic [7:0]       vec_lfsr_s;
   logic [ERR_W-1:0] err_n_s;
   logic [1:0]       phase_code_s;
   logic [2:0]       nxt_state_s;
   logic             nxt_rst_s;
   logic             nxt_sel_s;
   logic             nxt_d_s;
   logic             nxt_exp_s;

   // Next-state, compare result and the vector to apply at the next accepted edge
   always_comb begin
      start_ok_s   = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
      cmp_s        = busy_r && (tmr_r == TMR_LAST);
      mism_s       = (bus.dut_q !== exp_r);
      lfsr_n_s     = lfsr_next(lfsr_r);
      vec_lfsr_s   = start_ok_s ? LFSR_SEED : lfsr_n_s;
      nxt_state_s  = state_r;
      phase_code_s = 2'd0;
      nxt_rst_s    = 1'b1;
      nxt_sel_s    = 1'b0;
      nxt_d_s      = 1'b0;
      nxt_exp_s    = 1'b0;

      if (mism_s && (err_cnt_r != {ERR_W{1'b1}})) begin
         err_n_s = err_cnt_r + ERR_W'(1);
      end else begin
         err_n_s = err_cnt_r;
      end

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start_ok_s) begin
               nxt_state_s = ST_RESET_CHK;
            end else begin
               nxt_state_s = state_r;
            end
         end
         ST_RESET_CHK: begin
            phase_code_s = 2'd1;
            if (cmp_s) begin
               nxt_state_s = ST_LOAD_D0;
            end else begin
               nxt_state_s = state_r;
            end
         end
         ST_LOAD_D0: begin
            phase_code_s = 2'd2;
            if (cmp_s && (ph_cnt_r == PH_LAST)) begin
               nxt_state_s = ST_LOAD_D1;
            end else begin
               nxt_state_s = state_r;
            end
         end
         ST_LOAD_D1: begin
            phase_code_s = 2'd3;
            if (cmp_s && (ph_cnt_r == PH_LAST)) begin
               nxt_state_s = ST_DONE;
            end else begin
               nxt_state_s = state_r;
            end
         end
         default: begin
            nxt_state_s = ST_IDLE;
         end
      endcase

      // Parked (IDLE/DONE) keeps the flop in reset
      case (nxt_state_s)
         ST_RESET_CHK: begin
            nxt_rst_s = 1'b1;
            nxt_sel_s = vec_lfsr_s[1];
            nxt_d_s   = vec_lfsr_s[0];
            nxt_exp_s = 1'b0;
         end
         ST_LOAD_D0: begin
            nxt_rst_s = 1'b0;
            nxt_sel_s = 1'b0;
            nxt_d_s   = vec_lfsr_s[0];
            nxt_exp_s = vec_lfsr_s[0];
         end
         ST_LOAD_D1: begin
            nxt_rst_s = 1'b0;
            nxt_sel_s = 1'b1;
            nxt_d_s   = ~vec_lfsr_s[0];
            nxt_exp_s = vec_lfsr_s[0];
         end
         default: begin
            nxt_rst_s = 1'b1;
            nxt_sel_s = 1'b0;
            nxt_d_s   = 1'b0;
            nxt_exp_s = 1'b0;
         end
      endcase
   end

   // Run sequencing, vector application and result accumulation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         lfsr_r       <= LFSR_SEED;
         tmr_r        <= '0;
         ph_cnt_r     <= 8'd0;
         exp_r        <= 1'b0;
         dut_rst_r    <= 1'b1;
         dut_sel_r    <= 1'b0;
         dut_d_r      <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         err_cnt_r    <= '0;
         vec_cnt_r    <= 8'd0;
         fail_phase_r <= 2'd0;
      end else if (start_ok_s) begin
         state_r      <= nxt_state_s;
         lfsr_r       <= LFSR_SEED;
         tmr_r        <= '0;
         ph_cnt_r     <= 8'd0;
         exp_r        <= nxt_exp_s;
         dut_rst_r    <= nxt_rst_s;
         dut_sel_r    <= nxt_sel_s;
         dut_d_r      <= nxt_d_s;
         busy_r       <= 1'b1;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         err_cnt_r    <= '0;
         vec_cnt_r    <= 8'd0;
         fail_phase_r <= 2'd0;
      end else if (cmp_s) begin
         state_r   <= nxt_state_s;
         lfsr_r    <= lfsr_n_s;
         tmr_r     <= '0;
         ph_cnt_r  <= (nxt_state_s != state_r) ? 8'd0 : ph_cnt_r + 8'd1;
         exp_r     <= nxt_exp_s;
         dut_rst_r <= nxt_rst_s;
         dut_sel_r <= nxt_sel_s;
         dut_d_r   <= nxt_d_s;
         err_cnt_r <= err_n_s;
         vec_cnt_r <= vec_cnt_r + 8'd1;
         if (mism_s && (fail_phase_r == 2'd0)) begin
            fail_phase_r <= phase_code_s;
         end
         if (nxt_state_s == ST_DONE) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (err_n_s == '0);
         end
      end else if (busy_r) begin
         tmr_r <= tmr_r + TMR_W'(1);
      end
   end

   assign bus.dut_rst    = dut_rst_r;
   assign bus.dut_sel    = dut_sel_r;
   assign bus.dut_d      = dut_d_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.pass       = pass_r;
   assign bus.err_cnt    = err_cnt_r;
   assign bus.vec_cnt    = vec_cnt_r;
   assign bus.fail_phase = fail_phase_r;

endmodule
